// File: rtl/pwm_defs_pkg.sv
// Shared definitions for the PWM waveform generator: FSM encoding, period limit,
// dead-counter width and the phase wrap helper.
package pwm_defs;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } pwm_state_e;

  localparam logic [7:0] PWM_PERIOD_MAX = 8'd254;
  localparam int         DEAD_W         = 4;

  typedef logic [DEAD_W-1:0] dead_cnt_t;

  // Phase runs 0..PWM_PERIOD_MAX and wraps, giving a 255-tick period.
  function automatic logic [7:0] phase_next(input logic [7:0] phase);
    return (phase == PWM_PERIOD_MAX) ? 8'd0 : phase + 8'd1;
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Tick prescaler: a down-counter that fires a tick every clk_div+1 clocks while
// enabled and is held at zero otherwise, so the first enabled cycle ticks at once.
module pwm_prescaler #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] clk_div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (!enable) begin
      cnt_d = '0;
    end else if (cnt_q == '0) begin
      cnt_d = clk_div;
    end else begin
      cnt_d = cnt_q - DIV_WIDTH'(1);
    end
  end

  assign tick = enable && (cnt_q == '0);

  // NOTE: clocked state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pwm_gen.sv
// PWM waveform generator: applies ratio/direction requests glitch-free at period
// boundaries and inserts whole dead periods of zero drive on direction reversal.
module pwm_gen
  import pwm_defs::*;
#(
  parameter int DIV_WIDTH    = 8,
  parameter int DEAD_PERIODS = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 pwm_enable,
  input  logic                 pwm_update,
  input  logic [7:0]           pwm_ratio,
  input  logic                 pwm_direction,
  input  logic [DIV_WIDTH-1:0] clk_div,
  output logic                 pwm_done,
  output logic                 pwm_out,
  output logic                 dir_out
);

  pwm_state_e state_q, state_d;

  logic [7:0] phase_q, phase_d;
  logic [7:0] active_q, active_d;
  logic [7:0] pend_ratio_q, pend_ratio_d;
  logic       pend_dir_q, pend_dir_d;
  logic       pending_q, pending_d;
  dead_cnt_t  dead_q, dead_d;
  logic       dir_q, dir_d;
  logic       done_q, done_d;
  logic       pwm_out_q, pwm_out_d;

  logic run_active;
  logic tick;
  logic boundary;
  logic dead_last;
  logic apply;
  logic enter_dead;
  logic dead_dec;

  // Counting only runs while enabled and out of OFF; the enable-low cycle resets it.
  assign run_active = pwm_enable && (state_q != ST_OFF);
  assign boundary   = tick && (phase_q == PWM_PERIOD_MAX);
  assign dead_last  = (dead_q == dead_cnt_t'(1));

  pwm_prescaler #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .enable (run_active),
    .clk_div(clk_div),
    .tick   (tick)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_OFF;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!pwm_enable) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF:  state_d = ST_RUN;
        ST_RUN:  if (boundary && pending_q && (pend_dir_q != dir_q)) state_d = ST_DEAD;
        ST_DEAD: if (boundary && dead_last) state_d = ST_RUN;
        default: state_d = ST_OFF;
      endcase
    end
  end

  always_comb begin
    apply      = 1'b0;
    enter_dead = 1'b0;
    dead_dec   = 1'b0;
    case (state_q)
      ST_OFF: apply = pending_q;
      ST_RUN: begin
        if (boundary && pending_q) begin
          if (pend_dir_q == dir_q) apply = 1'b1;
          else                     enter_dead = 1'b1;
        end
      end
      ST_DEAD: begin
        if (boundary) begin
          if (dead_last) apply    = 1'b1;
          else           dead_dec = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    phase_d      = '0;
    pend_ratio_d = pend_ratio_q;
    pend_dir_d   = pend_dir_q;
    pending_d    = pending_q;
    active_d     = active_q;
    dir_d        = dir_q;
    dead_d       = dead_q;

    if (run_active) begin
      phase_d = tick ? phase_next(phase_q) : phase_q;
    end

    // A fresh capture wins over the clear, so an update on the applying edge stays pending.
    if (pwm_update) begin
      pending_d    = 1'b1;
      pend_ratio_d = pwm_ratio;
      pend_dir_d   = pwm_direction;
    end else if (apply) begin
      pending_d = 1'b0;
    end

    if (apply) begin
      active_d = pend_ratio_q;
      dir_d    = pend_dir_q;
    end else if (enter_dead) begin
      active_d = '0;
    end

    if (enter_dead) begin
      dead_d = dead_cnt_t'(DEAD_PERIODS);
    end else if (dead_dec) begin
      dead_d = dead_q - dead_cnt_t'(1);
    end

    done_d    = apply;
    pwm_out_d = run_active && (phase_q < active_q);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase_q      <= '0;
      active_q     <= '0;
      pend_ratio_q <= '0;
      pend_dir_q   <= 1'b0;
      pending_q    <= 1'b0;
      dead_q       <= '0;
      dir_q        <= 1'b0;
      done_q       <= 1'b0;
      pwm_out_q    <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      active_q     <= active_d;
      pend_ratio_q <= pend_ratio_d;
      pend_dir_q   <= pend_dir_d;
      pending_q    <= pending_d;
      dead_q       <= dead_d;
      dir_q        <= dir_d;
      done_q       <= done_d;
      pwm_out_q    <= pwm_out_d;
    end
  end

  assign pwm_done = done_q;
  assign pwm_out  = pwm_out_q;
  assign dir_out  = dir_q;

endmodule

// File: tb/tb_pwm_gen.sv
// Scoreboard bench for pwm_gen: stimulus queues expected acknowledgements, a
// negedge monitor pops them on pwm_done and checks direction, latency and waveform.
`timescale 1ns/1ps
module tb_pwm_gen;

  localparam int DIV_W   = 8;
  localparam int DEAD    = 2;
  localparam int TIMEOUT = 5000;

  logic             clock         = 1'b0;
  logic             reset         = 1'b1;
  logic             pwm_enable    = 1'b0;
  logic             pwm_update    = 1'b0;
  logic [7:0]       pwm_ratio     = '0;
  logic             pwm_direction = 1'b0;
  logic [DIV_W-1:0] clk_div       = '0;
  logic             pwm_done;
  logic             pwm_out;
  logic             dir_out;

  pwm_gen #(
    .DIV_WIDTH   (DIV_W),
    .DEAD_PERIODS(DEAD)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .pwm_enable   (pwm_enable),
    .pwm_update   (pwm_update),
    .pwm_ratio    (pwm_ratio),
    .pwm_direction(pwm_direction),
    .clk_div      (clk_div),
    .pwm_done     (pwm_done),
    .pwm_out      (pwm_out),
    .dir_out      (dir_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    int ratio;
    bit dir;
    int issue;
    int lat_min;
    int lat_max;
    bit dead;
    bit measure;
    bit expect_low;
  } exp_t;

  exp_t sb[$];

  int errors     = 0;
  int checks     = 0;
  int cyc        = 0;
  int done_count = 0;
  int last_done  = 0;
  int low_run    = 0;
  bit meas_busy  = 1'b0;
  int meas_k, meas_ratio, meas_bad, meas_high;

  task automatic check(input string name, input bit ok, input int actual, input int required);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, actual, required, cyc);
    end
  endtask

  // Level of pwm_out for the k-th clock of a period that starts at phase 0.
  function automatic bit exp_level(input int k, input int r, input int d);
    return (k / (d + 1)) < r;
  endfunction

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  initial forever begin
    exp_t e;
    int   d;
    @(negedge clock);
    if (reset) begin
      meas_busy = 1'b0;
      low_run   = 0;
    end else begin
      d       = int'(clk_div);
      low_run = pwm_out ? 0 : low_run + 1;
      if (meas_busy) begin
        if (pwm_out) meas_high++;
        if (pwm_out !== exp_level(meas_k, meas_ratio, d)) meas_bad++;
        meas_k++;
        if (meas_k == 255 * (d + 1)) begin
          check("period waveform (high clocks)", meas_bad == 0, meas_high, meas_ratio * (d + 1));
          meas_busy = 1'b0;
        end
      end
      if (pwm_done) begin
        done_count++;
        last_done = cyc;
        if (sb.size() == 0) begin
          check("unexpected pwm_done", 1'b0, 1, 0);
        end else begin
          e = sb.pop_front();
          check("dir_out at pwm_done", dir_out == e.dir, int'(dir_out), int'(e.dir));
          check("update-to-done latency", (cyc - e.issue >= e.lat_min) && (cyc - e.issue <= e.lat_max),
                cyc - e.issue, e.lat_max);
          if (e.dead)
            check("dead interval zero drive", low_run >= DEAD * 255 * (d + 1), low_run, DEAD * 255 * (d + 1));
          if (e.expect_low)
            check("pwm_out low in OFF", pwm_out == 1'b0, int'(pwm_out), 0);
          if (e.measure) begin
            meas_busy  = 1'b1;
            meas_k     = 0;
            meas_bad   = 0;
            meas_high  = 0;
            meas_ratio = e.ratio;
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic issue(input int r, input bit dir, input int lmin, input int lmax,
                       input bit dead, input bit meas, input bit low, input bit merge);
    exp_t e;
    pwm_update    = 1'b1;
    pwm_ratio     = 8'(r);
    pwm_direction = dir;
    if (merge && sb.size() > 0) begin
      sb[sb.size()-1].ratio = r;
      sb[sb.size()-1].dir   = dir;
    end else begin
      e.ratio      = r;
      e.dir        = dir;
      e.issue      = cyc;
      e.lat_min    = lmin;
      e.lat_max    = lmax;
      e.dead       = dead;
      e.measure    = meas;
      e.expect_low = low;
      sb.push_back(e);
    end
    step(1);
    pwm_update = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((sb.size() != 0 || meas_busy) && n < TIMEOUT) begin
      step(1);
      n++;
    end
    check({name, " completes in time"}, n < TIMEOUT, n, TIMEOUT);
    if (n >= TIMEOUT) sb.delete();
  endtask

  task automatic check_period(input string name, input int r);
    int d    = int'(clk_div);
    int bad  = 0;
    int high = 0;
    for (int k = 0; k < 255 * (d + 1); k++) begin
      @(negedge clock);
      if (pwm_out) high++;
      if (pwm_out !== exp_level(k, r, d)) bad++;
    end
    check(name, bad == 0, high, r * (d + 1));
    step(1);
  endtask

  task automatic check_hold(input string name, input int r, input int n);
    int d   = int'(clk_div);
    int bad = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      if (pwm_out !== ((((cyc - 1 - last_done) / (d + 1)) % 255) < r)) bad++;
    end
    check(name, bad == 0, bad, 0);
    step(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pre;
    bit mdir;

    step(2);
    check("reset pwm_out", pwm_out == 1'b0, int'(pwm_out), 0);
    check("reset dir_out", dir_out == 1'b0, int'(dir_out), 0);
    check("reset pwm_done", pwm_done == 1'b0, int'(pwm_done), 0);
    reset = 1'b0;
    step(2);
    pwm_enable = 1'b1;
    step(3);

    issue(64, 1'b0, 2, 256, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_idle("ratio 64");
    issue(0, 1'b0, 2, 256, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_idle("ratio 0");
    issue(255, 1'b0, 2, 256, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_idle("ratio 255");
    issue(100, 1'b0, 2, 256, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_idle("ratio 100");

    issue(50, 1'b1, DEAD * 255 + 2, (DEAD + 1) * 255 + 1, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_idle("reversal to ratio 50");

    issue(10, 1'b1, 2, 256, 1'b0, 1'b1, 1'b0, 1'b0);
    step(3);
    issue(20, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_hold("no mid-period duty change", 50, 100);
    wait_idle("last-wins update");

    // Wait idle leaves us at phase 1, so 253 clocks later is the boundary clock.
    step(253);
    issue(128, 1'b1, 256, 256, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_idle("update on boundary");

    pwm_enable = 1'b0;
    step(3);
    check("pwm_out low when disabled", pwm_out == 1'b0, int'(pwm_out), 0);
    issue(30, 1'b0, 2, 2, 1'b0, 1'b0, 1'b1, 1'b0);
    issue(77, 1'b1, 2, 2, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_idle("OFF updates");
    check("dir_out after OFF apply", dir_out == 1'b1, int'(dir_out), 1);
    pwm_enable = 1'b1;
    step(2);
    check_period("re-enable duty 77 from phase 0", 77);

    issue(40, 1'b0, DEAD * 255 + 2, (DEAD + 1) * 255 + 1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(300);
    check("dir_out held during dead", dir_out == 1'b1, int'(dir_out), 1);
    check("pwm_out zero during dead", pwm_out == 1'b0, int'(pwm_out), 0);
    #1;
    reset = 1'b1;
    #1;
    check("async reset dir_out", dir_out == 1'b0, int'(dir_out), 0);
    check("async reset pwm_out", pwm_out == 1'b0, int'(pwm_out), 0);
    check("async reset pwm_done", pwm_done == 1'b0, int'(pwm_done), 0);
    sb.delete();
    pre = done_count;
    step(2);
    reset      = 1'b0;
    pwm_enable = 1'b0;
    step(20);
    check("no done for lost request", done_count == pre, done_count, pre);
    pwm_enable = 1'b1;
    step(2);
    check_period("idle ratio 0 after reset", 0);
    check("still no done after reset", done_count == pre, done_count, pre);

    mdir = 1'b0;
    for (int i = 0; i < 6; i++) begin
      int d, r, p, lmin, lmax;
      bit nd, rev;
      pwm_enable = 1'b0;
      d          = $urandom_range(0, 1);
      clk_div    = DIV_W'(d);
      step(2);
      pwm_enable = 1'b1;
      step($urandom_range(1, 40));
      if (i == 0)      r = 0;
      else if (i == 1) r = 255;
      else             r = $urandom_range(0, 255);
      nd   = 1'($urandom_range(0, 1));
      rev  = (nd != mdir);
      p    = 255 * (d + 1);
      lmin = rev ? DEAD * p + 2 : 2;
      lmax = rev ? (DEAD + 1) * p + 1 : p + 1;
      issue(r, nd, lmin, lmax, rev, 1'b1, 1'b0, 1'b0);
      wait_idle("random update");
      mdir = nd;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_gen.md
# pwm_gen

PWM waveform generator directly downstream of the PWM control stage. It consumes the `pwm_ratio` / `pwm_direction` / `pwm_update` request and produces the motor-driver `pwm_out` and `dir_out` pins. New ratios are applied glitch-free, only at PWM period boundaries, and each applied request is acknowledged with a one-cycle `pwm_done`. A reversal of direction inserts a dead interval of zero drive before the direction pin changes.

## Interface
Parameters:
- `DIV_WIDTH`, default 8: width of the prescaler divide input.
- `DEAD_PERIODS`, default 4: number of full PWM periods with zero drive on a direction reversal. Legal range 1..15.

Ports:
- `clock`  in  1: main clock; single clock domain.
- `reset`  in  1: asynchronous, active-high reset.
- `pwm_enable`  in  1: enables drive; low forces `pwm_out`=0.
- `pwm_update`  in  1: one-cycle request to apply `pwm_ratio`/`pwm_direction`.
- `pwm_ratio`  in  8: requested high-time out of 255 ticks.
- `pwm_direction`  in  1: requested motor direction.
- `clk_div`  in  DIV_WIDTH: a tick occurs every `clk_div`+1 clocks.
- `pwm_done`  out  1: one-cycle pulse when a request has been applied.
- `pwm_out`  out  1: PWM drive to the motor driver.
- `dir_out`  out  1: direction pin to the motor driver.

## Operation
- Prescaler:
  - Down-counter reloads `clk_div` and asserts `tick` when it reaches 0.
  - A `clk_div` change takes effect at the next reload.
- Phase counter:
  - 8-bit, advances on each `tick`, counts 0..254, then wraps to 0. The period is 255 ticks.
  - A boundary is a `tick` with phase==254.
- Output: `pwm_out` = enabled && phase < `active_ratio`.
  - Ratio 0 gives a constant low output.
  - Ratio 255 gives a constant high output.
- Request capture:
  - `pwm_update` loads `pend_ratio` and `pend_dir` and sets `pending`.
  - A further update while `pending` is set overwrites the pending values; last one wins, and only one `pwm_done` is issued.
- FSM states: OFF, RUN, DEAD.
- OFF (`pwm_enable`=0):
  - Prescaler and phase are held at 0; `pwm_out`=0.
  - A pending request is applied on the next edge, including direction; no dead time. `pwm_done` pulses.
- OFF -> RUN: when `pwm_enable` rises. Phase starts at 0.
- RUN, at a boundary with `pending`:
  - If `pend_dir` == `dir_out`: load `active_ratio`, clear `pending`, pulse `pwm_done`.
  - Otherwise: set `active_ratio`=0, load the dead counter with `DEAD_PERIODS`, go to DEAD.
- DEAD:
  - The dead counter decrements at each boundary.
  - At 0: load `dir_out` and `active_ratio` from the pending values (current at that moment), clear `pending`, pulse `pwm_done`, go to RUN.
  - Updates arriving during DEAD overwrite the pending values. If the final `pend_dir` equals `dir_out`, the dead interval still completes.
- `pwm_enable` falling in any state: go to OFF on the next edge and force `pwm_out`=0. A pending request, including one from an aborted DEAD, is then applied per OFF rules.

## Timing
- Reset values: `pwm_out`=0, `dir_out`=0, `pwm_done`=0.
- Reset values of internal state: `active_ratio`=0, `pending`=0, phase=0, prescaler=0, state=OFF.
- `pwm_out` is registered and lags phase by one clock.
- `pwm_done` is registered. It is high for exactly the one cycle after the edge that loads `active_ratio`. The first period at the new ratio begins in that same cycle.
- Update coincident with a boundary: not bypassed. It becomes pending for the next boundary.
- Update coincident with `pwm_done` in OFF: applied on the following edge, giving a second `pwm_done`.
- Worst-case latency in RUN: 255·(`clk_div`+1)+1 clocks from `pwm_update` to `pwm_done`.
- Worst-case latency on reversal: additionally `DEAD_PERIODS`·255·(`clk_div`+1) clocks.
- Latency in OFF: `pwm_done` 2 clocks after `pwm_update` (capture, then apply).
- Reset asserted mid-period or mid-DEAD: all outputs go to reset values immediately (asynchronous). No `pwm_done` is emitted for a lost request.

## Structure
- Shared package/include `pwm_defs`:
  - FSM state encodings (OFF, RUN, DEAD).
  - `PWM_PERIOD_MAX`=254.
  - Width constant for the dead counter (4 bits).
- Sub-module `pwm_prescaler`: `clock`, `reset`, `enable`, `clk_div`, producing `tick`.
- The phase counter, capture registers and FSM live in `pwm_gen`.

## Test plan
- Reset, enable, `clk_div`=0, update ratio 64 dir 0 -> `pwm_done` within 257 clocks; thereafter `pwm_out` high 64 of every 255 clocks; `dir_out`=0.
- Ratio 0 then ratio 255 (each after `pwm_done`) -> `pwm_out` constant 0 for a full period, then constant 1 for a full period; no glitch at boundaries.
- Running at ratio 100 dir 0, `DEAD_PERIODS`=2, update ratio 50 dir 1 -> `pwm_out`=0 for 510 clocks after the next boundary, then `dir_out`=1, `pwm_done`, 50/255 duty.
- Two updates in one period (ratio 10, then 20) -> exactly one `pwm_done` at the boundary; duty 20/255; a mid-period duty change never appears.
- `pwm_enable`=0, update ratio 77 dir 1 -> `pwm_done` 2 clocks later, `dir_out`=1, `pwm_out` stays 0; re-enable gives 77/255 duty from phase 0.
- Assert `reset` during DEAD with a request pending -> outputs 0 immediately, no `pwm_done`; after release, state is OFF with `pending`=0.
